// File: rtl/qcw_ramp_sequencer_if.sv
// Signal bundle between the QCW burst sequencer and its surroundings (request side and PLL side).
// Debug state is carried alongside so checkers can bind to the sequencer FSM.
interface qcw_ramp_sequencer_if;
    // fire is a level request acted on only at its rising edge (no ready/ack); pll_start is a
    // single-cycle strobe, and pll_done/pll_fault are levels whose rising edge is the event.
    logic        fire;
    logic        ocp_trip;
    logic        fault_clear;
    logic [7:0]  ramp_start;
    logic [7:0]  ramp_end;
    logic [7:0]  ramp_step;
    logic [15:0] pulse_cycles;
    logic        pll_cycle_finished;
    logic        pll_done;
    logic        pll_fault;
    logic        pll_start;
    logic        pll_halt;
    logic [7:0]  phase_shift;
    logic [15:0] cycle_limit;
    logic        busy;
    logic        fault_latched;
    logic [2:0]  dbg_state;

    modport master (
        output fire, ocp_trip, fault_clear, ramp_start, ramp_end, ramp_step, pulse_cycles,
               pll_cycle_finished, pll_done, pll_fault,
        input  pll_start, pll_halt, phase_shift, cycle_limit, busy, fault_latched, dbg_state
    );

    modport slave (
        input  fire, ocp_trip, fault_clear, ramp_start, ramp_end, ramp_step, pulse_cycles,
               pll_cycle_finished, pll_done, pll_fault,
        output pll_start, pll_halt, phase_shift, cycle_limit, busy, fault_latched, dbg_state
    );
endinterface

// File: rtl/qcw_ramp_sequencer.sv
// QCW burst sequencer: starts the PLL on a fire edge, ramps phase_shift toward ramp_end,
// forwards overcurrent as a sticky halt, latches faults and enforces a holdoff between bursts.
module qcw_ramp_sequencer #(
    parameter int RAMP_DIV     = 4,
    parameter int HOLDOFF_CLKS = 1000000,
    parameter int TIMEOUT_CLKS = 2000000
) (
    input  logic                 clk,
    input  logic                 rst,
    qcw_ramp_sequencer_if.slave  bus
);
    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int HLD_W = (HOLDOFF_CLKS > 1) ? $clog2(HOLDOFF_CLKS) : 1;
    localparam int TMO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLDOFF_CLKS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_RUN     = 3'd2,
        S_FAULT   = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_fire_d, r_done_d, r_fault_d;
    logic [7:0]        r_start_sh, r_end_sh, r_step_sh;
    logic [DIV_W-1:0]  r_div;
    logic [TMO_W-1:0]  r_tmo;
    logic [HLD_W-1:0]  r_hold;
    logic              r_pll_start, r_pll_halt, r_busy, r_fault_latched;
    logic [7:0]        r_phase;
    logic [15:0]       r_limit;

    logic              w_fire_edge, w_done_edge, w_fault_edge, w_up;
    logic [8:0]        w_sum, w_diff;
    logic [7:0]        w_next_phase;

    assign w_fire_edge  = bus.fire & ~r_fire_d;
    assign w_done_edge  = bus.pll_done & ~r_done_d;
    assign w_fault_edge = bus.pll_fault & ~r_fault_d;
    assign w_up         = (r_end_sh >= r_start_sh);
    assign w_sum        = {1'b0, r_phase} + {1'b0, r_step_sh};
    assign w_diff       = {1'b0, r_phase} - {1'b0, r_step_sh};

    // Ninth bit catches wrap past 255 or below 0, so the ramp clamps at ramp_end instead.
    always_comb begin
        w_next_phase = r_phase;
        if (w_up) begin
            w_next_phase = (w_sum >= {1'b0, r_end_sh}) ? r_end_sh : w_sum[7:0];
        end else begin
            w_next_phase = (w_diff[8] || (w_diff[7:0] <= r_end_sh)) ? r_end_sh : w_diff[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_fire_d        <= 1'b0;
            r_done_d        <= 1'b0;
            r_fault_d       <= 1'b0;
            r_start_sh      <= 8'd0;
            r_end_sh        <= 8'd0;
            r_step_sh       <= 8'd0;
            r_div           <= '0;
            r_tmo           <= '0;
            r_hold          <= '0;
            r_pll_start     <= 1'b0;
            r_pll_halt      <= 1'b0;
            r_busy          <= 1'b0;
            r_fault_latched <= 1'b0;
            r_phase         <= 8'd0;
            r_limit         <= 16'd0;
        end else begin
            r_fire_d    <= bus.fire;
            r_done_d    <= bus.pll_done;
            r_fault_d   <= bus.pll_fault;
            r_pll_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fire_edge) begin
                        r_start_sh  <= bus.ramp_start;
                        r_end_sh    <= bus.ramp_end;
                        r_step_sh   <= bus.ramp_step;
                        r_phase     <= bus.ramp_start;
                        r_limit     <= bus.pulse_cycles;
                        r_pll_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    r_div   <= '0;
                    r_tmo   <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (bus.pll_cycle_finished) begin
                        if (r_div == DIV_LAST) begin
                            r_div   <= '0;
                            r_phase <= w_next_phase;
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end
                    if (bus.ocp_trip) r_pll_halt <= 1'b1;
                    // A fault edge or timeout wins over a done edge arriving on the same clock.
                    if (w_fault_edge || (r_tmo == TMO_LAST)) begin
                        r_pll_halt      <= 1'b0;
                        r_fault_latched <= 1'b1;
                        r_state         <= S_FAULT;
                    end else if (w_done_edge) begin
                        r_pll_halt <= 1'b0;
                        r_hold     <= '0;
                        r_state    <= S_HOLDOFF;
                    end
                end
                S_FAULT: begin
                    if (bus.fault_clear) begin
                        r_fault_latched <= 1'b0;
                        r_hold          <= '0;
                        r_state         <= S_HOLDOFF;
                    end
                end
                S_HOLDOFF: begin
                    if (r_hold == HLD_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pll_start     = r_pll_start;
    assign bus.pll_halt      = r_pll_halt;
    assign bus.phase_shift   = r_phase;
    assign bus.cycle_limit   = r_limit;
    assign bus.busy          = r_busy;
    assign bus.fault_latched = r_fault_latched;
    assign bus.dbg_state     = r_state;
endmodule
